mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/cpu_types_pkg.sv | 13 +
 rtl/diaosi_types_pkg.sv | 10 +
 rtl/mem_arb_tmo.sv | 37 +++
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus word and the RAM status encoding reported on ramstate.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

endpackage

// File: rtl/diaosi_types_pkg.sv
// Memory-arbiter grant states; the state register is the only record of who owns the RAM.
package diaosi_types_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_I    = 2'd1,
    ARB_D    = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arb_tmo.sv
// Granted-access watchdog: counts granted cycles, tc flags the last permitted cycle.
module mem_arb_tmo #(
  parameter int RAM_TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam int W = (RAM_TIMEOUT > 1) ? $clog2(RAM_TIMEOUT) : 1;

  logic [W-1:0] cnt_q, cnt_d;

  // NOTE: give every always_comb output a default first so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == W'(RAM_TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (icache/dcache) single-port RAM arbiter with timeout and sticky error.
// Define MEM_ARBITER_RR_EN for round-robin priority; default build gives dcache fixed priority.
module mem_arbiter
  import cpu_types_pkg::*;
  import diaosi_types_pkg::*;
#(
  parameter int RAM_TIMEOUT = 64
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        iwait,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dwait,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        err
);

  arb_state_t state_q, state_d;
  logic       err_q, err_d;
  logic       ireq, dreq, granted, tmo_tc, d_first;
  logic       hit, bad;
  ramstate_t  rs;

  assign rs    = ramstate_t'(ramstate);
  assign ireq  = iREN;
  assign dreq  = dREN | dWEN;
  assign iload = ramload;
  assign dload = ramload;
  assign err   = err_q;

  // A granted access ends on ACCESS, on ERROR, or when the watchdog runs out.
  assign hit = (rs == ACCESS) || (rs == ERROR) || tmo_tc;
  assign bad = (rs != ACCESS);

`ifdef MEM_ARBITER_RR_EN
  logic last_d_q, last_d_d;
  assign d_first = !last_d_q;
`else
  assign d_first = 1'b1;
`endif

  mem_arb_tmo #(.RAM_TIMEOUT(RAM_TIMEOUT)) u_tmo (
    .clk   (CLK),
    .rst_n (nRST),
    .clear (state_q == ARB_IDLE),
    .en    (granted),
    .tc    (tmo_tc)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    granted  = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = ireq;
    dwait    = dreq;
`ifdef MEM_ARBITER_RR_EN
    last_d_d = last_d_q;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (dreq && (!ireq || d_first)) begin
          state_d = ARB_D;
`ifdef MEM_ARBITER_RR_EN
          last_d_d = 1'b1;
`endif
        end else if (ireq) begin
          state_d = ARB_I;
`ifdef MEM_ARBITER_RR_EN
          last_d_d = 1'b0;
`endif
        end
      end
      ARB_I: begin
        granted = 1'b1;
        ramREN  = 1'b1;
        ramaddr = iaddr;
        // A dropped request aborts silently: wait stays high, no error.
        iwait   = !(ireq && hit);
        if (!ireq) begin
          state_d = ARB_IDLE;
        end else if (hit) begin
          state_d = ARB_IDLE;
          err_d   = err_q | bad;
        end
      end
      ARB_D: begin
        granted  = 1'b1;
        ramWEN   = dWEN;
        ramREN   = !dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        dwait    = !(dreq && hit);
        if (!dreq) begin
          state_d = ARB_IDLE;
        end else if (hit) begin
          state_d = ARB_IDLE;
          err_d   = err_q | bad;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ARB_IDLE;
      err_q    <= 1'b0;
`ifdef MEM_ARBITER_RR_EN
      last_d_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      err_q    <= err_d;
`ifdef MEM_ARBITER_RR_EN
      last_d_q <= last_d_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle vector table plus timeout, reset and priority sequences.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  localparam int TMO = 8;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [1:0]  ramstate;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        iwait, dwait, ramREN, ramWEN, err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  mem_arbiter #(.RAM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dwait(dwait),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  typedef struct {
    logic        ir, dr, dw;
    logic [31:0] ia, da, ds;
    logic [1:0]  rs;
    logic [31:0] rl;
    logic        eiw, edw, eren, ewen;
    logic [31:0] ea, es;
    logic        eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic ir, dr, dw, input logic [31:0] ia, da, ds,
                              input logic [1:0] rs, input logic [31:0] rl,
                              input logic eiw, edw, eren, ewen,
                              input logic [31:0] ea, es, input logic eerr);
    vec_t v;
    v.ir = ir; v.dr = dr; v.dw = dw; v.ia = ia; v.da = da; v.ds = ds;
    v.rs = rs; v.rl = rl; v.eiw = eiw; v.edw = edw; v.eren = eren; v.ewen = ewen;
    v.ea = ea; v.es = es; v.eerr = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drv(input logic ir, dr, dw, input logic [31:0] ia, da, ds,
                     input logic [1:0] rs, input logic [31:0] rl);
    iREN = ir; dREN = dr; dWEN = dw; iaddr = ia; daddr = da; dstore = ds;
    ramstate = rs; ramload = rl;
  endtask

  localparam logic [31:0] DS = 32'h1234_5678;
  localparam logic [31:0] DX = 32'hA5A5_A5A5;

  initial begin
    // Reset with requests already present: no enables, waits follow requests.
    nRST = 1'b0;
    drv(1, 0, 1, 32'h200, 32'h100, DS, FREE, 0);
    #2;
    check("rst.ramREN", ramREN, 0);
    check("rst.ramWEN", ramWEN, 0);
    check("rst.ramaddr", ramaddr, 0);
    check("rst.ramstore", ramstore, 0);
    check("rst.err", err, 0);
    check("rst.iwait", iwait, 1);

    // Simultaneous write+fetch (dcache first), plain fetch, BUSYx3 fetch, abort, ERROR.
    tbl.push_back(mk(1,0,1, 32'h200,32'h100,DS, FREE,  0,            1,1,0,0, 0,0, 0));
    tbl.push_back(mk(1,0,1, 32'h200,32'h100,DS, BUSY,  0,            1,1,0,1, 32'h100,DS, 0));
    tbl.push_back(mk(1,0,1, 32'h200,32'h100,DS, ACCESS,32'h55,       1,0,0,1, 32'h100,DS, 0));
    tbl.push_back(mk(1,0,0, 32'h200,0,0,        FREE,  0,            1,0,0,0, 0,0, 0));
    tbl.push_back(mk(1,0,0, 32'h200,0,0,        ACCESS,32'hCAFEF00D, 0,0,1,0, 32'h200,0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,              FREE,  0,            0,0,0,0, 0,0, 0));
    tbl.push_back(mk(1,0,0, 32'h40,0,0,         FREE,  0,            1,0,0,0, 0,0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1,0,0, 32'h40,0,0,       BUSY,  32'h1111_1111,1,0,1,0, 32'h40,0, 0));
    tbl.push_back(mk(1,0,0, 32'h40,0,0,         ACCESS,32'hDEADBEEF, 0,0,1,0, 32'h40,0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,              FREE,  0,            0,0,0,0, 0,0, 0));
    tbl.push_back(mk(0,1,0, 0,32'h300,DX,       FREE,  0,            0,1,0,0, 0,0, 0));
    tbl.push_back(mk(1,1,0, 32'h500,32'h300,DX, BUSY,  0,            1,1,1,0, 32'h300,DX, 0));
    tbl.push_back(mk(1,0,0, 32'h500,32'h300,DX, BUSY,  0,            1,1,1,0, 32'h300,DX, 0));
    tbl.push_back(mk(1,0,0, 32'h500,0,0,        FREE,  0,            1,0,0,0, 0,0, 0));
    tbl.push_back(mk(1,0,0, 32'h500,0,0,        ACCESS,32'h0BADF00D, 0,0,1,0, 32'h500,0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,              FREE,  0,            0,0,0,0, 0,0, 0));
    tbl.push_back(mk(1,0,0, 32'h600,0,0,        FREE,  0,            1,0,0,0, 0,0, 0));
    tbl.push_back(mk(1,0,0, 32'h600,0,0,        ERROR, 32'h77,       0,0,1,0, 32'h600,0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0,              FREE,  0,            0,0,0,0, 0,0, 1));

    @(negedge CLK);
    nRST = 1'b1;
    for (int i = 0; i < tbl.size(); i++) begin
      drv(tbl[i].ir, tbl[i].dr, tbl[i].dw, tbl[i].ia, tbl[i].da, tbl[i].ds, tbl[i].rs, tbl[i].rl);
      #1;
      check($sformatf("v%0d.iwait", i), iwait, tbl[i].eiw);
      check($sformatf("v%0d.dwait", i), dwait, tbl[i].edw);
      check($sformatf("v%0d.ramREN", i), ramREN, tbl[i].eren);
      check($sformatf("v%0d.ramWEN", i), ramWEN, tbl[i].ewen);
      check($sformatf("v%0d.ramaddr", i), ramaddr, tbl[i].ea);
      check($sformatf("v%0d.ramstore", i), ramstore, tbl[i].es);
      check($sformatf("v%0d.iload", i), iload, tbl[i].rl);
      check($sformatf("v%0d.dload", i), dload, tbl[i].rl);
      check($sformatf("v%0d.err", i), err, tbl[i].eerr);
      @(negedge CLK);
    end

    // Timeout: RAM stuck BUSY, dwait low on 8th granted cycle, err sticky afterwards.
    nRST = 1'b0;
    drv(0, 0, 0, 0, 0, 0, FREE, 0);
    #1 check("tmo.rst_err", err, 0);
    #1 nRST = 1'b1;
    @(negedge CLK);
    drv(0, 1, 0, 0, 32'h700, 0, BUSY, 32'h5);
    #1 check("tmo.idle_dwait", dwait, 1);
    @(negedge CLK);
    for (int k = 1; k <= TMO; k++) begin
      #1;
      check($sformatf("tmo.c%0d.dwait", k), dwait, (k == TMO) ? 1'b0 : 1'b1);
      check($sformatf("tmo.c%0d.ramREN", k), ramREN, 1);
      check($sformatf("tmo.c%0d.err", k), err, 0);
      @(negedge CLK);
    end
    drv(0, 0, 0, 0, 0, 0, FREE, 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("tmo.after%0d.err", k), err, 1);
      check($sformatf("tmo.after%0d.ramREN", k), ramREN, 0);
      @(negedge CLK);
    end

    // Reset pulsed in the middle of a granted write.
    drv(0, 0, 1, 0, 32'h800, 32'hFEED_0001, BUSY, 0);
    #1 check("mrst.idle_wen", ramWEN, 0);
    @(negedge CLK);
    #1;
    check("mrst.wen_before", ramWEN, 1);
    check("mrst.err_before", err, 1);
    #1 nRST = 1'b0;
    #1;
    check("mrst.wen", ramWEN, 0);
    check("mrst.addr", ramaddr, 0);
    check("mrst.store", ramstore, 0);
    check("mrst.err", err, 0);
    @(negedge CLK);
    nRST = 1'b1;
    drv(0, 1, 0, 0, 32'h900, 0, FREE, 0);
    #1;
    check("post.idle_dwait", dwait, 1);
    check("post.idle_ren", ramREN, 0);
    @(negedge CLK);
    drv(0, 1, 0, 0, 32'h900, 0, ACCESS, 32'h9999);
    #1;
    check("post.dwait", dwait, 0);
    check("post.ren", ramREN, 1);
    check("post.addr", ramaddr, 32'h900);
    check("post.dload", dload, 32'h9999);
    @(negedge CLK);

    // Simultaneous requests after a data grant: round-robin favours the fetch.
    drv(1, 0, 1, 32'hA00, 32'hB00, 32'h1, FREE, 0);
    #1;
    check("prio.idle_iwait", iwait, 1);
    check("prio.idle_dwait", dwait, 1);
    @(negedge CLK);
    drv(1, 0, 1, 32'hA00, 32'hB00, 32'h1, ACCESS, 32'h42);
    #1;
`ifdef MEM_ARBITER_RR_EN
    check("prio.wen", ramWEN, 0);
    check("prio.ren", ramREN, 1);
    check("prio.addr", ramaddr, 32'hA00);
    check("prio.iwait", iwait, 0);
    check("prio.dwait", dwait, 1);
`else
    check("prio.wen", ramWEN, 1);
    check("prio.ren", ramREN, 0);
    check("prio.addr", ramaddr, 32'hB00);
    check("prio.iwait", iwait, 1);
    check("prio.dwait", dwait, 0);
`endif
    @(negedge CLK);
    drv(0, 0, 0, 0, 0, 0, FREE, 0);
    repeat (2) @(negedge CLK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
